// File: rtl/speaker_match_pkg.sv
// Shared types and width helpers for the speaker_match cosine-similarity matcher.
package speaker_match_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_SCORE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Cycles spent per user in SCORE beyond the SCORE_FRAC quotient bits.
  localparam int USER_OVERHEAD = 3;

  function automatic int acc_w(input int feat_w, input int feat_len);
    return 2 * feat_w + $clog2(feat_len);
  endfunction

  function automatic int score_w(input int score_frac);
    return score_frac + 1;
  endfunction

  function automatic int user_cycles(input int score_frac);
    return score_frac + USER_OVERHEAD;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring divider: one quotient bit per cycle after a load cycle, done pulses once.
// Precondition: dividend >> Q_W is smaller than divisor, so Q_W bits hold the quotient.
module seq_divider #(
  parameter int DVD_W = 8,
  parameter int DVS_W = 8,
  parameter int Q_W   = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             clear,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             done,
  output logic [Q_W-1:0]   quotient
);

  localparam int CW = $clog2(Q_W + 1);

  logic [DVS_W-1:0] rem_r;
  logic [Q_W-1:0]   lo_r;
  logic [DVS_W-1:0] dvs_r;
  logic [CW-1:0]    cnt_r;
  logic [DVS_W:0]   shift_s;
  logic [DVS_W:0]   diff_s;
  logic             ge_s;

  // Trial subtraction; remainder < divisor keeps the difference inside DVS_W bits.
  always_comb begin
    shift_s = {rem_r, lo_r[Q_W-1]};
    diff_s  = shift_s - {1'b0, dvs_r};
    ge_s    = ~diff_s[DVS_W];
  end

  // Load on start, then shift in one quotient bit per cycle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rem_r    <= '0;
      lo_r     <= '0;
      dvs_r    <= '0;
      cnt_r    <= '0;
      done     <= 1'b0;
      quotient <= '0;
    end else if (clear) begin
      cnt_r <= '0;
      done  <= 1'b0;
    end else if (start) begin
      rem_r    <= DVS_W'(dividend[DVD_W-1:Q_W]);
      lo_r     <= dividend[Q_W-1:0];
      dvs_r    <= divisor;
      cnt_r    <= CW'(Q_W);
      done     <= 1'b0;
      quotient <= '0;
    end else if (cnt_r != '0) begin
      rem_r    <= ge_s ? diff_s[DVS_W-1:0] : shift_s[DVS_W-1:0];
      lo_r     <= {lo_r[Q_W-2:0], 1'b0};
      quotient <= {quotient[Q_W-2:0], ge_s};
      cnt_r    <= cnt_r - 1'b1;
      done     <= (cnt_r == CW'(1));
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: rtl/speaker_match.sv
// Speaker matcher: accumulates energy/correlation per frame, scores every enrolled
// template by cos^2 similarity with a shared divider and reports the best match.
module speaker_match
  import speaker_match_pkg::*;
#(
  parameter int FEAT_W     = 16,
  parameter int FEAT_LEN   = 16,
  parameter int N_USER     = 4,
  parameter int SCORE_FRAC = 15
) (
  input  logic                           sys_clk,
  input  logic                           sys_rst_n,
  input  logic                           tmpl_wr_en,
  input  logic [$clog2(N_USER)-1:0]      tmpl_wr_user,
  input  logic [$clog2(FEAT_LEN)-1:0]    tmpl_wr_idx,
  input  logic signed [FEAT_W-1:0]       tmpl_wr_data,
  input  logic signed [FEAT_W-1:0]       feature_in,
  input  logic                           feature_in_en,
  output logic                           feature_in_ready,
  input  logic                           frame_abort,
  input  logic [score_w(SCORE_FRAC)-1:0] threshold,
  output logic                           result_valid,
  output logic [$clog2(N_USER)-1:0]      result_user,
  output logic [score_w(SCORE_FRAC)-1:0] result_score,
  output logic                           result_reject,
  output logic                           busy
);

  localparam int UW    = $clog2(N_USER);
  localparam int IW    = $clog2(FEAT_LEN);
  localparam int AW    = acc_w(FEAT_W, FEAT_LEN);
  localparam int SW    = score_w(SCORE_FRAC);
  localparam int PW    = 2 * FEAT_W;
  localparam int CW    = $clog2(user_cycles(SCORE_FRAC));
  localparam int DVS_W = 2 * AW;
  localparam int DVD_W = 2 * AW + SCORE_FRAC;
  localparam logic [SW-1:0] SCORE_ONE = {1'b1, {SCORE_FRAC{1'b0}}};

  state_t                   state_r;
  logic signed [FEAT_W-1:0] tmpl_r [N_USER][FEAT_LEN];
  logic [IW-1:0]            idx_r;
  logic [UW-1:0]            user_r;
  logic [CW-1:0]            cyc_r;
  logic [AW-1:0]            e_acc_r;
  logic signed [AW-1:0]     d_acc_r [N_USER];
  logic [AW-1:0]            n_acc_r [N_USER];
  logic [SW-1:0]            best_score_r;
  logic [UW-1:0]            best_user_r;

  logic                     take_s, abort_s, operands_ok_s, div_start_s, div_done_s;
  logic signed [PW-1:0]     xx_s;
  logic signed [PW-1:0]     xt_s [N_USER];
  logic signed [PW-1:0]     tt_s [N_USER];
  logic signed [AW-1:0]     d_sel_s;
  logic [AW-1:0]            n_sel_s;
  logic [DVS_W-1:0]         d_sq_s, divisor_s;
  logic [DVD_W-1:0]         dividend_s;
  logic [SW-1:0]            quotient_s, score_s, cand_score_s;
  logic [UW-1:0]            cand_user_s;

  assign feature_in_ready = (state_r == ST_IDLE) || (state_r == ST_ACCUM);
  assign busy             = (state_r != ST_IDLE);
  assign take_s           = feature_in_en && feature_in_ready && !frame_abort;
  assign abort_s          = frame_abort && ((state_r == ST_ACCUM) || (state_r == ST_SCORE));

  // Per-sample products for energy, correlation and template norms.
  always_comb begin
    xx_s = PW'(feature_in) * PW'(feature_in);
    for (int k = 0; k < N_USER; k++) begin
      xt_s[k] = PW'(feature_in) * PW'(tmpl_r[k][idx_r]);
      tt_s[k] = PW'(tmpl_r[k][idx_r]) * PW'(tmpl_r[k][idx_r]);
    end
  end

  // Divider operands for the current user, saturated score and running argmax.
  always_comb begin
    d_sel_s    = d_acc_r[user_r];
    n_sel_s    = n_acc_r[user_r];
    d_sq_s     = DVS_W'($unsigned(d_sel_s)) * DVS_W'($unsigned(d_sel_s));
    dividend_s = {d_sq_s, {SCORE_FRAC{1'b0}}};
    divisor_s  = DVS_W'(e_acc_r) * DVS_W'(n_sel_s);
    if (!d_sel_s[AW-1] && (d_sel_s != '0) && (e_acc_r != '0) && (n_sel_s != '0)) begin
      operands_ok_s = 1'b1;
    end else begin
      operands_ok_s = 1'b0;
    end
    if ((state_r == ST_SCORE) && (cyc_r == '0) && operands_ok_s && !frame_abort) begin
      div_start_s = 1'b1;
    end else begin
      div_start_s = 1'b0;
    end
    // A skipped user never starts the divider, so done stays low and the score is 0.
    if (div_done_s) begin
      if (quotient_s > SCORE_ONE) begin
        score_s = SCORE_ONE;
      end else begin
        score_s = quotient_s;
      end
    end else begin
      score_s = '0;
    end
    if (score_s > best_score_r) begin
      cand_score_s = score_s;
      cand_user_s  = user_r;
    end else begin
      cand_score_s = best_score_r;
      cand_user_s  = best_user_r;
    end
  end

  seq_divider #(
    .DVD_W (DVD_W),
    .DVS_W (DVS_W),
    .Q_W   (SW)
  ) u_div (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clear     (abort_s),
    .start     (div_start_s),
    .dividend  (dividend_s),
    .divisor   (divisor_s),
    .done      (div_done_s),
    .quotient  (quotient_s)
  );

  // Template store, writable only while idle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int k = 0; k < N_USER; k++) begin
        for (int i = 0; i < FEAT_LEN; i++) begin
          tmpl_r[k][i] <= '0;
        end
      end
    end else if (tmpl_wr_en && (state_r == ST_IDLE) &&
                 (int'(tmpl_wr_user) < N_USER) && (int'(tmpl_wr_idx) < FEAT_LEN)) begin
      tmpl_r[tmpl_wr_user][tmpl_wr_idx] <= tmpl_wr_data;
    end
  end

  // Frame FSM with accumulators, per-user scoring sequence and result registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r       <= ST_IDLE;
      idx_r         <= '0;
      user_r        <= '0;
      cyc_r         <= '0;
      e_acc_r       <= '0;
      for (int k = 0; k < N_USER; k++) begin
        d_acc_r[k] <= '0;
        n_acc_r[k] <= '0;
      end
      best_score_r  <= '0;
      best_user_r   <= '0;
      result_valid  <= 1'b0;
      result_user   <= '0;
      result_score  <= '0;
      result_reject <= 1'b0;
    end else if (abort_s) begin
      state_r      <= ST_IDLE;
      idx_r        <= '0;
      user_r       <= '0;
      cyc_r        <= '0;
      e_acc_r      <= '0;
      for (int k = 0; k < N_USER; k++) begin
        d_acc_r[k] <= '0;
        n_acc_r[k] <= '0;
      end
      best_score_r <= '0;
      best_user_r  <= '0;
      result_valid <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_ACCUM: begin
          if (take_s) begin
            e_acc_r <= e_acc_r + AW'($unsigned(xx_s));
            for (int k = 0; k < N_USER; k++) begin
              d_acc_r[k] <= d_acc_r[k] + AW'(xt_s[k]);
              n_acc_r[k] <= n_acc_r[k] + AW'($unsigned(tt_s[k]));
            end
            if (idx_r == IW'(FEAT_LEN - 1)) begin
              idx_r        <= '0;
              user_r       <= '0;
              cyc_r        <= '0;
              best_score_r <= '0;
              best_user_r  <= '0;
              state_r      <= ST_SCORE;
            end else begin
              idx_r   <= idx_r + 1'b1;
              state_r <= ST_ACCUM;
            end
          end
        end
        ST_SCORE: begin
          if (cyc_r == CW'(user_cycles(SCORE_FRAC) - 1)) begin
            best_score_r <= cand_score_s;
            best_user_r  <= cand_user_s;
            cyc_r        <= '0;
            if (user_r == UW'(N_USER - 1)) begin
              user_r        <= '0;
              e_acc_r       <= '0;
              for (int k = 0; k < N_USER; k++) begin
                d_acc_r[k] <= '0;
                n_acc_r[k] <= '0;
              end
              result_valid  <= 1'b1;
              result_user   <= cand_user_s;
              result_score  <= cand_score_s;
              result_reject <= (cand_score_s < threshold);
              state_r       <= ST_DONE;
            end else begin
              user_r <= user_r + 1'b1;
            end
          end else begin
            cyc_r <= cyc_r + 1'b1;
          end
        end
        ST_DONE: begin
          result_valid <= 1'b0;
          state_r      <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_speaker_match.sv
// Scoreboard bench for speaker_match with FEAT_LEN=4, N_USER=4, SCORE_FRAC=15.
module tb_speaker_match;

  localparam int LAT = 4 * (15 + 3) + 1;

  typedef struct {
    int user;
    int score;
    int rej;
    int t0;
  } exp_t;

  logic               sys_clk = 1'b0;
  logic               sys_rst_n;
  logic               tmpl_wr_en;
  logic [1:0]         tmpl_wr_user;
  logic [1:0]         tmpl_wr_idx;
  logic signed [15:0] tmpl_wr_data;
  logic signed [15:0] feature_in;
  logic               feature_in_en;
  logic               feature_in_ready;
  logic               frame_abort;
  logic [15:0]        threshold;
  logic               result_valid;
  logic [1:0]         result_user;
  logic [15:0]        result_score;
  logic               result_reject;
  logic               busy;

  int   total = 0;
  int   bad = 0;
  int   pos_cnt = 0;
  exp_t exp_q[$];
  int   frame_v[4];
  int   tmpl_a[16] = '{-1, 2, 2, -3,  -2, 2, 2, -4,  -1, -2, 1, -5,  -1, 2, 1, -6};
  int   tmpl_c[16] = '{1, 1, 1, 1,  0, 0, 0, 0,  1, 1, 1, 1,  0, 0, 0, 0};

  speaker_match #(
    .FEAT_W     (16),
    .FEAT_LEN   (4),
    .N_USER     (4),
    .SCORE_FRAC (15)
  ) dut (
    .sys_clk          (sys_clk),
    .sys_rst_n        (sys_rst_n),
    .tmpl_wr_en       (tmpl_wr_en),
    .tmpl_wr_user     (tmpl_wr_user),
    .tmpl_wr_idx      (tmpl_wr_idx),
    .tmpl_wr_data     (tmpl_wr_data),
    .feature_in       (feature_in),
    .feature_in_en    (feature_in_en),
    .feature_in_ready (feature_in_ready),
    .frame_abort      (frame_abort),
    .threshold        (threshold),
    .result_valid     (result_valid),
    .result_user      (result_user),
    .result_score     (result_score),
    .result_reject    (result_reject),
    .busy             (busy)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) pos_cnt <= pos_cnt + 1;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge sys_clk);
      if (result_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("result_user", result_user, e.user);
          check("result_score", result_score, e.score);
          check("result_reject", result_reject, e.rej);
          check("result_latency", pos_cnt - e.t0, LAT);
        end
      end
    end
  endtask

  task automatic wr_tmpl(input int u, input int i, input int v);
    @(negedge sys_clk);
    tmpl_wr_en   = 1'b1;
    tmpl_wr_user = 2'(u);
    tmpl_wr_idx  = 2'(i);
    tmpl_wr_data = 16'(v);
    @(negedge sys_clk);
    tmpl_wr_en   = 1'b0;
  endtask

  task automatic load_tmpl(input int t[16]);
    for (int k = 0; k < 16; k++) wr_tmpl(k / 4, k % 4, t[k]);
  endtask

  task automatic set_frame(input int a, input int b, input int c, input int d);
    frame_v[0] = a; frame_v[1] = b; frame_v[2] = c; frame_v[3] = d;
  endtask

  // Drives one frame from a negedge; pushes the expected result with the last-sample time.
  task automatic send_frame(input int gap, input bit exp_en, input int eu, input int es, input int er);
    for (int i = 0; i < 4; i++) begin
      repeat (gap) @(negedge sys_clk);
      feature_in    = 16'(frame_v[i]);
      feature_in_en = 1'b1;
      if (i == 3 && exp_en) exp_q.push_back('{eu, es, er, pos_cnt});
      @(negedge sys_clk);
      feature_in_en = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 300) begin
      @(negedge sys_clk);
      n++;
    end
    check("idle_reached", busy, 0);
  endtask

  initial begin
    sys_rst_n     = 1'b0;
    tmpl_wr_en    = 1'b0;
    tmpl_wr_user  = 2'd0;
    tmpl_wr_idx   = 2'd0;
    tmpl_wr_data  = 16'sd0;
    feature_in    = 16'sd0;
    feature_in_en = 1'b0;
    frame_abort   = 1'b0;
    threshold     = 16'd0;
    fork
      monitor();
    join_none
    repeat (3) @(negedge sys_clk);
    check("rst_valid", result_valid, 0);
    check("rst_user", result_user, 0);
    check("rst_score", result_score, 0);
    check("rst_reject", result_reject, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", feature_in_ready, 1);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    // Reference templates: user 1 matches the input exactly.
    load_tmpl(tmpl_a);
    set_frame(-2, 2, 2, -4);
    send_frame(0, 1'b1, 1, 32768, 0);
    check("busy_in_score", busy, 1);
    check("ready_in_score", feature_in_ready, 0);
    wait_idle();
    threshold = 16'd32769;
    send_frame(1, 1'b1, 1, 32768, 1);
    wait_idle();
    repeat (5) @(negedge sys_clk);
    check("hold_user", result_user, 1);
    check("hold_score", result_score, 32768);
    check("hold_reject", result_reject, 1);

    // Anti-correlated input: every correlation negative, all scores 0.
    threshold = 16'd0;
    set_frame(2, -2, -2, 4);
    send_frame(0, 1'b1, 0, 0, 0);
    wait_idle();

    // Template writes while scoring must be ignored.
    set_frame(-2, 2, 2, -4);
    send_frame(0, 1'b1, 1, 32768, 0);
    wr_tmpl(1, 0, 7);
    wr_tmpl(3, 3, 0);
    wait_idle();
    send_frame(0, 1'b1, 1, 32768, 0);
    wait_idle();

    // Abort in SCORE: no result, outputs keep the previous result.
    send_frame(0, 1'b0, 0, 0, 0);
    repeat (20) @(negedge sys_clk);
    frame_abort = 1'b1;
    @(negedge sys_clk);
    frame_abort = 1'b0;
    check("abort_score_busy", busy, 0);
    check("abort_keep_user", result_user, 1);
    check("abort_keep_score", result_score, 32768);
    check("abort_keep_reject", result_reject, 0);

    // Tie between users 0 and 2; abort with a sample in IDLE discards the sample.
    load_tmpl(tmpl_c);
    feature_in    = 16'sd9;
    feature_in_en = 1'b1;
    frame_abort   = 1'b1;
    @(negedge sys_clk);
    feature_in_en = 1'b0;
    frame_abort   = 1'b0;
    check("idle_abort_busy", busy, 0);
    set_frame(3, 3, 3, 3);
    send_frame(0, 1'b1, 0, 32768, 0);
    wait_idle();

    // Abort after two samples, coinciding with a third; then a stalled new frame.
    for (int i = 0; i < 2; i++) begin
      feature_in    = 16'sd5;
      feature_in_en = 1'b1;
      @(negedge sys_clk);
      feature_in_en = 1'b0;
    end
    feature_in    = 16'sd5;
    feature_in_en = 1'b1;
    frame_abort   = 1'b1;
    @(negedge sys_clk);
    feature_in_en = 1'b0;
    frame_abort   = 1'b0;
    check("accum_abort_busy", busy, 0);
    set_frame(1, 2, 3, 4);
    send_frame(2, 1'b1, 0, 27306, 0);
    wait_idle();

    // Zero input: every score 0, rejected at threshold 1.
    threshold = 16'd1;
    set_frame(0, 0, 0, 0);
    send_frame(0, 1'b1, 0, 0, 1);
    wait_idle();

    // Reset mid-division: no result, outputs and templates cleared.
    set_frame(3, 3, 3, 3);
    send_frame(0, 1'b0, 0, 0, 0);
    repeat (30) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_user", result_user, 0);
    check("rst_mid_score", result_score, 0);
    check("rst_mid_reject", result_reject, 0);
    send_frame(0, 1'b1, 0, 0, 1);
    wait_idle();

    repeat (5) @(negedge sys_clk);
    check("pending_results", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
